// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC, next-PC adder and one-deep fetch FSM.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned commit targets.
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_a_src,
  input  logic            pc_b_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            commit,
  output logic            ifu_req_valid,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_req_ready,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_addr,
`endif
  output logic            inst_valid
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EXEC,
    TRAP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] next_pc;

  // The address is the PC register itself, so it cannot move mid-request.
  assign ifu_req_addr = pc;

  always_comb begin
    op_a    = pc_a_src ? imm : XLEN'(4);
    op_b    = pc_b_src ? rs1 : pc;
    sum     = op_a + op_b;
    next_pc = sum;
    if (pc_a_src && pc_b_src) begin
      next_pc[0] = 1'b0;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |next_pc[1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      ifu_req_valid <= 1'b0;
      inst          <= 32'h0;
      inst_valid    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
      bad_addr      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state         <= REQ;
          ifu_req_valid <= 1'b1;
        end
        REQ: begin
          if (ifu_req_ready) begin
            state         <= WAIT;
            ifu_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (ifu_rsp_valid) begin
            state      <= EXEC;
            inst       <= ifu_rsp_data;
            inst_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (commit) begin
            inst_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            if (misaligned) begin
              state         <= TRAP;
              misalign_trap <= 1'b1;
              bad_addr      <= next_pc;
            end else begin
              state         <= REQ;
              pc            <= next_pc;
              ifu_req_valid <= 1'b1;
            end
`else
            state         <= REQ;
            pc            <= next_pc;
            ifu_req_valid <= 1'b1;
`endif
          end
        end
        TRAP: begin
          // Sticky until reset: no fetches, nothing to commit.
          ifu_req_valid <= 1'b0;
          inst_valid    <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          ifu_req_valid <= 1'b0;
          inst_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed + random fetch/commit traffic vs a PC model.
// Build with PC_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_a_src;
  logic        pc_b_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        commit;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] bad_addr;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_a_src      (pc_a_src),
    .pc_b_src      (pc_b_src),
    .imm           (imm),
    .rs1           (rs1),
    .commit        (commit),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .pc            (pc),
    .inst          (inst),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_trap (misalign_trap),
    .bad_addr      (bad_addr),
`endif
    .inst_valid    (inst_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule, written from the ISA view.
  function automatic logic [31:0] ref_next(input logic a, input logic b,
                                           input logic [31:0] i,
                                           input logic [31:0] r,
                                           input logic [31:0] p);
    logic [31:0] t;
    t = (a ? i : 32'd4) + (b ? r : p);
    if (a && b) t = t & 32'hFFFF_FFFE;
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    commit = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_pc = RPC;
    chk("rst_pc", pc, RPC);
    chk("rst_req_valid_c0", {31'b0, ifu_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("rst_trap", {31'b0, misalign_trap}, 32'd0);
    chk("rst_bad_addr", bad_addr, 32'd0);
`endif
    step();
    chk("rst_req_valid_c1", {31'b0, ifu_req_valid}, 32'd1);
    chk("rst_req_addr", ifu_req_addr, RPC);
  endtask

  task automatic do_instr(input logic a, input logic b,
                          input logic [31:0] i, input logic [31:0] r,
                          input int rdy_dly, input int rsp_dly,
                          input int cmt_dly, output logic trapped);
    int t;
    logic [31:0] exp;
    trapped = 1'b0;
    t = 0;
    while (!ifu_req_valid && t < 20) begin
      step();
      t++;
    end
    chk("req_seen", {31'b0, ifu_req_valid}, 32'd1);
    chk("req_addr", ifu_req_addr, m_pc);
    for (int k = 0; k < rdy_dly; k++) begin
      ifu_req_ready = 1'b0;
      commit = 1'b1;
      pc_a_src = 1'b1;
      imm = 32'h40;
      step();
      commit = 1'b0;
      chk("req_hold_valid", {31'b0, ifu_req_valid}, 32'd1);
      chk("req_hold_addr", ifu_req_addr, m_pc);
      chk("req_hold_pc", pc, m_pc);
    end
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk("wait_req_low", {31'b0, ifu_req_valid}, 32'd0);
    for (int k = 0; k < rsp_dly; k++) begin
      step();
      chk("wait_no_inst", {31'b0, inst_valid}, 32'd0);
    end
    m_inst = $urandom;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data = m_inst;
    step();
    ifu_rsp_valid = 1'b0;
    chk("inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("inst", inst, m_inst);
    for (int k = 0; k < cmt_dly; k++) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data = ~m_inst;
      step();
      ifu_rsp_valid = 1'b0;
      chk("exec_inst_hold", inst, m_inst);
      chk("exec_pc_hold", pc, m_pc);
    end
    pc_a_src = a;
    pc_b_src = b;
    imm = i;
    rs1 = r;
    commit = 1'b1;
    exp = ref_next(a, b, i, r, m_pc);
    step();
    commit = 1'b0;
    chk("commit_inst_valid", {31'b0, inst_valid}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    if (exp[1:0] != 2'b00) begin
      trapped = 1'b1;
      chk("trap_flag", {31'b0, misalign_trap}, 32'd1);
      chk("trap_bad_addr", bad_addr, exp);
      chk("trap_pc_hold", pc, m_pc);
      for (int k = 0; k < 3; k++) begin
        step();
        chk("trap_no_req", {31'b0, ifu_req_valid}, 32'd0);
        chk("trap_no_inst", {31'b0, inst_valid}, 32'd0);
      end
      return;
    end
    chk("no_trap", {31'b0, misalign_trap}, 32'd0);
`endif
    m_pc = exp;
    chk("next_pc", pc, m_pc);
    chk("next_req", {31'b0, ifu_req_valid}, 32'd1);
    chk("next_addr", ifu_req_addr, m_pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic tr;
    rst = 1'b1;
    pc_a_src = 1'b0;
    pc_b_src = 1'b0;
    imm = '0;
    rs1 = '0;
    commit = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data = '0;
    m_pc = RPC;
    m_inst = '0;

    do_reset();
    do_instr(0, 0, 0, 0, 0, 0, 0, tr);
    chk("seq_pc", pc, 32'h8000_0004);
    do_instr(0, 0, 0, 0, 3, 1, 1, tr);
    do_instr(0, 0, 0, 0, 0, 2, 0, tr);
    do_instr(0, 0, 0, 0, 1, 0, 2, tr);
    chk("seq4_pc", pc, 32'h8000_0010);
    do_instr(1, 0, 32'hFFFF_FFF8, 0, 0, 0, 0, tr);
    chk("branch_pc", pc, 32'h8000_0008);
    do_instr(1, 1, 0, 32'h8000_1001, 0, 0, 0, tr);
    chk("jalr_pc", pc, 32'h8000_1000);
    do_instr(1, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, tr);
    do_instr(0, 0, 0, 0, 0, 0, 0, tr);
    chk("wrap_pc", pc, 32'h0000_0000);
    do_instr(1, 1, 0, 32'h8000_1003, 0, 0, 0, tr);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_trap", {31'b0, misalign_trap}, 32'd1);
    chk("mis_bad_addr", bad_addr, 32'h8000_1002);
    chk("mis_pc", pc, 32'h0000_0000);
`else
    chk("mis_pc", pc, 32'h8000_1002);
    do_instr(0, 0, 0, 0, 0, 0, 0, tr);
    chk("mis_seq_pc", pc, 32'h8000_1006);
`endif

    // Reset while waiting for a response.
    do_reset();
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst_req_valid", {31'b0, ifu_req_valid}, 32'd0);
    chk("midrst_pc", pc, RPC);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data = 32'hDEAD_BEEF;
    step();
    ifu_rsp_valid = 1'b0;
    chk("midrst_req_again", {31'b0, ifu_req_valid}, 32'd1);
    chk("midrst_no_inst", {31'b0, inst_valid}, 32'd0);
    m_pc = RPC;

    for (int n = 0; n < 60; n++) begin
      logic a;
      logic b;
      logic [31:0] ri;
      logic [31:0] rr;
      a = 1'($urandom);
      b = 1'($urandom);
      ri = $urandom;
      rr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ri = ri & 32'hFFFF_FFFC;
        rr = rr & 32'hFFFF_FFFC;
      end
      do_instr(a, b, ri, rr,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), tr);
      if (tr) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
